neureka_binconv_pe_sequencer: RTL and testbench
===============================================

// Module: neureka_binconv_pe_sequencer
// PURPOSE
// Sequences one neureka_binconv_pe through an output tile: clears the PE, issues QW weight-bit beats per input-channel chunk,
// drives scale_shift / dw_accum / enable, and counts in-flight partial results until drained. Sits between the weight/activation
// streamers and the PE control struct inside the engine; handshakes with streamers (inputs) and the accumulator (PE output).
// PARAMETERS
// QW_MAX        8   max weight bits per beat group (scale_shift range 0..QW_MAX-1)
// KIN_W         16  width of channel-chunk counter
// MAX_INFLIGHT  2   max issued beats whose PE result has not been accepted downstream (>=1)
// PORTS
// clk_i            in   1      clock
// rst_i            in   1      asynchronous reset, active-high
// clear_i          in   1      synchronous abort, highest priority
// start_i          in   1      start tile; sampled only in IDLE
// cfg_qw_i         in   4      weight bits per chunk (0..QW_MAX), latched at start
// cfg_kin_iter_i   in   KIN_W  channel chunks per tile, latched at start
// cfg_dw_i         in   1      depthwise mode, latched at start
// act_valid_i      in   1      activation streamer has beat
// wgt_valid_i      in   1      weight streamer has beat
// act_ready_o      out  1      activation beat consumed
// wgt_ready_o      out  1      weight beat consumed
// pres_valid_i     in   1      PE result valid (column or depthwise path)
// pres_ready_i     in   1      accumulator accepts PE result
// pe_clear_o       out  1      PE clear pulse
// pe_enable_o      out  1      PE enable (beat issued this cycle)
// pe_dw_accum_o    out  1      drives ctrl dw_accum
// pe_scale_shift_o out  3      current weight-bit index
// last_beat_o      out  1      issued beat is last of tile
// busy_o           out  1      state != IDLE
// done_o           out  1      one-cycle tile-complete pulse
// BEHAVIOUR
// Reset: state IDLE; all outputs 0; counters, inflight count and latched cfg cleared.
// FSM: IDLE -start_i-> CLEAR (1 cycle, pe_clear_o=1) -> RUN, or -> DRAIN if latched qw==0 or kin_iter==0.
//   RUN: fire = act_valid_i & wgt_valid_i & (inflight<MAX_INFLIGHT | pres_dec); act_ready_o=wgt_ready_o=pe_enable_o=fire.
//   pres_dec = pres_valid_i & pres_ready_i. Ready outputs never asserted outside RUN.
//   Counters on fire: bit_cnt 0..qw-1 inner (pe_scale_shift_o=bit_cnt), wraps to 0 and increments chunk_cnt 0..kin_iter-1.
//   last_beat_o = fire & bit_cnt==qw-1 & chunk_cnt==kin_iter-1; that fire moves RUN -> DRAIN.
//   DRAIN: wait until inflight==0 (counting same-cycle dec) -> DONE. DONE: done_o=1 for one cycle -> IDLE.
// Inflight: +1 on fire, -1 on pres_dec, both same cycle -> unchanged; never exceeds MAX_INFLIGHT nor underflows
//   (pres_dec with inflight==0 ignored; assertion flags it).
// pe_dw_accum_o = latched cfg_dw while busy_o, else 0.
// clear_i in any state: next state IDLE, counters/inflight zeroed, pe_clear_o=1 that cycle, no fire, no done_o.
// start_i outside IDLE ignored; start_i with clear_i same cycle: clear wins.
// Latency: start_i -> pe_clear_o next cycle; first possible fire 2 cycles after start_i.
// Min tile time with streams always valid and MAX_INFLIGHT met: 2 + qw*kin_iter + drain + 1 cycles.
// TESTING
// start, qw=8, kin=2, streams always valid, pres returns 1 cycle after fire -> 16 fires, shift 0..7 twice, last on 16th, one done_o.
// qw=0 or kin=0 -> CLEAR, DRAIN, DONE: no fire, done_o 3 cycles after start_i.
// MAX_INFLIGHT=2, pres_ready_i held 0 -> exactly 2 fires then stall; release -> fires resume, no lost/duplicate beat.
// wgt_valid_i toggling 50% -> fires only when both valid; bit/chunk counters advance only on fire.
// clear_i mid-RUN (after 5 fires) -> IDLE next cycle, pe_clear_o=1, no done_o; new start runs full tile correctly.
// cfg_dw=1, qw=4, kin=3 -> pe_dw_accum_o=1 throughout busy, 12 fires, 0 after done_o.

Source files
------------

// File: rtl/neureka_binconv_pe_sequencer_if.sv
// Control/handshake bundle between the binconv PE sequencer
// and its streamers, accumulator and PE control struct.
interface neureka_binconv_pe_sequencer_if #(
    parameter int KIN_W = 16
);
    logic             clear_i;
    logic             start_i;
    logic [3:0]       cfg_qw_i;
    logic [KIN_W-1:0] cfg_kin_iter_i;
    logic             cfg_dw_i;
    logic             act_valid_i;
    logic             wgt_valid_i;
    logic             act_ready_o;
    logic             wgt_ready_o;
    logic             pres_valid_i;
    logic             pres_ready_i;
    logic             pe_clear_o;
    logic             pe_enable_o;
    logic             pe_dw_accum_o;
    logic [2:0]       pe_scale_shift_o;
    logic             last_beat_o;
    logic             busy_o;
    logic             done_o;

    // Engine side: drives control, config and stream status.
    modport master (
        output clear_i, start_i, cfg_qw_i, cfg_kin_iter_i, cfg_dw_i,
        output act_valid_i, wgt_valid_i, pres_valid_i, pres_ready_i,
        input  act_ready_o, wgt_ready_o, pe_clear_o, pe_enable_o,
        input  pe_dw_accum_o, pe_scale_shift_o, last_beat_o,
        input  busy_o, done_o
    );

    // Sequencer side.
    modport slave (
        input  clear_i, start_i, cfg_qw_i, cfg_kin_iter_i, cfg_dw_i,
        input  act_valid_i, wgt_valid_i, pres_valid_i, pres_ready_i,
        output act_ready_o, wgt_ready_o, pe_clear_o, pe_enable_o,
        output pe_dw_accum_o, pe_scale_shift_o, last_beat_o,
        output busy_o, done_o
    );
endinterface

// File: rtl/neureka_binconv_pe_sequencer.sv
// Binconv PE sequencer: clears the PE, issues weight-bit beats per
// channel chunk and tracks in-flight PE results until drained.
module neureka_binconv_pe_sequencer #(
    parameter int QW_MAX       = 8,
    parameter int KIN_W        = 16,
    parameter int MAX_INFLIGHT = 2
) (
    input logic                          clk_i,
    input logic                          rst_i,
    neureka_binconv_pe_sequencer_if.slave bus
);
    localparam int IF_W = $clog2(MAX_INFLIGHT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       qw_q, qw_d;
    logic [KIN_W-1:0] kin_q, kin_d;
    logic             dw_q, dw_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [KIN_W-1:0] chunk_cnt_q, chunk_cnt_d;
    logic [IF_W-1:0]  inflight_q, inflight_d;

    logic pres_dec;
    logic fire;
    logic bit_wrap;
    logic chunk_last;
    logic last_beat;

    // Beat issue: needs both streams and a free in-flight slot,
    // where a result retiring this cycle frees its slot at once.
    always_comb begin
        pres_dec   = bus.pres_valid_i & bus.pres_ready_i
                   & (inflight_q != '0);
        fire       = (state_q == S_RUN) & ~bus.clear_i
                   & bus.act_valid_i & bus.wgt_valid_i
                   & ((inflight_q < IF_W'(MAX_INFLIGHT)) | pres_dec);
        bit_wrap   = (bit_cnt_q == qw_q - 4'd1);
        chunk_last = (chunk_cnt_q == kin_q - KIN_W'(1));
        last_beat  = fire & bit_wrap & chunk_last;
    end

    // Config latch, bit/chunk counters and in-flight tracking.
    always_comb begin
        qw_d        = qw_q;
        kin_d       = kin_q;
        dw_d        = dw_q;
        bit_cnt_d   = bit_cnt_q;
        chunk_cnt_d = chunk_cnt_q;
        inflight_d  = inflight_q;
        if (bus.clear_i) begin
            bit_cnt_d   = '0;
            chunk_cnt_d = '0;
            inflight_d  = '0;
        end else begin
            if (state_q == S_IDLE && bus.start_i) begin
                // Out-of-range bit counts saturate to the PE's maximum.
                qw_d        = (bus.cfg_qw_i > 4'(QW_MAX)) ?
                              4'(QW_MAX) : bus.cfg_qw_i;
                kin_d       = bus.cfg_kin_iter_i;
                dw_d        = bus.cfg_dw_i;
                bit_cnt_d   = '0;
                chunk_cnt_d = '0;
            end
            if (fire) begin
                if (bit_wrap) begin
                    bit_cnt_d   = '0;
                    chunk_cnt_d = chunk_cnt_q + KIN_W'(1);
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            case ({fire, pres_dec})
                2'b10:   inflight_d = inflight_q + IF_W'(1);
                2'b01:   inflight_d = inflight_q - IF_W'(1);
                default: inflight_d = inflight_q;
            endcase
        end
    end

    // Next-state logic; abort overrides every transition.
    always_comb begin
        state_d = state_q;
        if (bus.clear_i) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE:  if (bus.start_i) state_d = S_CLEAR;
                S_CLEAR: state_d = (qw_q == '0 || kin_q == '0) ?
                                   S_DRAIN : S_RUN;
                S_RUN:   if (last_beat) state_d = S_DRAIN;
                S_DRAIN: if (inflight_d == '0) state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            qw_q        <= '0;
            kin_q       <= '0;
            dw_q        <= 1'b0;
            bit_cnt_q   <= '0;
            chunk_cnt_q <= '0;
            inflight_q  <= '0;
        end else begin
            state_q     <= state_d;
            qw_q        <= qw_d;
            kin_q       <= kin_d;
            dw_q        <= dw_d;
            bit_cnt_q   <= bit_cnt_d;
            chunk_cnt_q <= chunk_cnt_d;
            inflight_q  <= inflight_d;
        end
    end

    // Output decode from state and the current beat.
    always_comb begin
        bus.act_ready_o      = fire;
        bus.wgt_ready_o      = fire;
        bus.pe_enable_o      = fire;
        bus.pe_clear_o       = bus.clear_i | (state_q == S_CLEAR);
        bus.pe_scale_shift_o = bit_cnt_q[2:0];
        bus.last_beat_o      = last_beat;
        bus.busy_o           = (state_q != S_IDLE);
        bus.done_o           = (state_q == S_DONE) & ~bus.clear_i;
        bus.pe_dw_accum_o    = dw_q & (state_q != S_IDLE);
    end

    // A retiring result with nothing in flight means the
    // accumulator and sequencer have lost sync.
    a_no_underflow: assert property (
        @(posedge clk_i) disable iff (rst_i)
        !(bus.pres_valid_i && bus.pres_ready_i && inflight_q == '0));

    a_inflight_bound: assert property (
        @(posedge clk_i) disable iff (rst_i)
        inflight_q <= IF_W'(MAX_INFLIGHT));
endmodule

// File: tb/tb_neureka_binconv_pe_sequencer.sv
// Randomised bench for the binconv PE sequencer against a
// beat-count reference model of one tile.
module tb_neureka_binconv_pe_sequencer;
    localparam int QW_MAX = 8;
    localparam int KIN_W  = 16;
    localparam int MAXI   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    neureka_binconv_pe_sequencer_if #(.KIN_W(KIN_W)) bus ();

    neureka_binconv_pe_sequencer #(
        .QW_MAX(QW_MAX),
        .KIN_W(KIN_W),
        .MAX_INFLIGHT(MAXI)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model of a tile in terms of beats and results.
    bit m_busy      = 1'b0;
    bit m_done_pend = 1'b0;
    bit m_dw        = 1'b0;
    int m_age       = 0;
    int m_qw        = 0;
    int m_issued    = 0;
    int m_total     = 0;
    int m_inflight  = 0;

    int n_fire  = 0;
    int n_done  = 0;
    int cur_qw  = 0;
    int cur_kin = 0;
    bit cur_dw  = 1'b0;
    int steps   = 0;

    task automatic chk(string tag, logic [31:0] obs,
                       logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d",
                   tag, obs, exp);
        end
    endtask

    task automatic step(bit act, bit wgt, bit pv, bit pr,
                        bit st, bit clr);
        bit dec, efire, eclr, edone;
        @(negedge clk);
        bus.start_i        = st;
        bus.clear_i        = clr;
        bus.act_valid_i    = act;
        bus.wgt_valid_i    = wgt;
        bus.pres_valid_i   = pv && (m_inflight > 0);
        bus.pres_ready_i   = pr;
        bus.cfg_qw_i       = 4'(cur_qw);
        bus.cfg_kin_iter_i = KIN_W'(cur_kin);
        bus.cfg_dw_i       = cur_dw;
        #1;
        dec   = pv && pr && (m_inflight > 0);
        efire = m_busy && !clr && m_age >= 2
             && m_issued < m_total && act && wgt
             && (m_inflight < MAXI || dec);
        eclr  = clr || (m_busy && m_age == 1);
        edone = m_busy && !clr && m_done_pend;
        chk("act_ready", bus.act_ready_o, efire);
        chk("wgt_ready", bus.wgt_ready_o, efire);
        chk("pe_enable", bus.pe_enable_o, efire);
        chk("pe_clear", bus.pe_clear_o, eclr);
        chk("busy", bus.busy_o, m_busy);
        chk("done", bus.done_o, edone);
        chk("dw_accum", bus.pe_dw_accum_o, m_busy && m_dw);
        chk("last_beat", bus.last_beat_o,
            efire && (m_issued == m_total - 1));
        if (efire)
            chk("scale_shift", bus.pe_scale_shift_o,
                m_issued % m_qw);
        n_fire += int'(bus.pe_enable_o);
        n_done += int'(bus.done_o);
        @(posedge clk);
        if (clr) begin
            m_busy      = 1'b0;
            m_done_pend = 1'b0;
            m_inflight  = 0;
        end else if (!m_busy) begin
            if (st) begin
                m_busy   = 1'b1;
                m_age    = 1;
                m_qw     = (cur_qw > QW_MAX) ? QW_MAX : cur_qw;
                m_dw     = cur_dw;
                m_total  = m_qw * cur_kin;
                m_issued = 0;
            end
        end else if (m_done_pend) begin
            m_busy      = 1'b0;
            m_done_pend = 1'b0;
        end else begin
            bit drain;
            drain = m_age >= 2 && m_issued == m_total;
            m_inflight += int'(efire) - int'(dec);
            if (efire) m_issued++;
            if (drain && m_inflight == 0) m_done_pend = 1'b1;
            if (m_age < 1000) m_age++;
        end
    endtask

    task automatic run_tile(int qw, int kin, bit dw, int mode);
        cur_qw  = qw;
        cur_kin = kin;
        cur_dw  = dw;
        n_fire  = 0;
        n_done  = 0;
        steps   = 0;
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3000 && m_busy; i++) begin
            steps++;
            case (mode)
                0: step(1'b1, 1'b1, 1'b1, 1'b1,
                        1'($urandom % 2), 1'b0);
                1: step(1'b1, 1'($urandom % 2), 1'b1,
                        1'($urandom % 2), 1'b0, 1'b0);
                default: begin
                    cur_qw  = $urandom_range(0, QW_MAX);
                    cur_kin = $urandom_range(0, 4);
                    step(1'($urandom % 2), 1'($urandom % 2),
                         1'($urandom % 2), 1'($urandom % 2),
                         1'($urandom % 2), 1'b0);
                end
            endcase
        end
        chk("tile_timeout", m_busy, 0);
    endtask

    initial begin
        int q, k;
        bus.start_i        = 1'b0;
        bus.clear_i        = 1'b0;
        bus.act_valid_i    = 1'b0;
        bus.wgt_valid_i    = 1'b0;
        bus.pres_valid_i   = 1'b0;
        bus.pres_ready_i   = 1'b0;
        bus.cfg_qw_i       = '0;
        bus.cfg_kin_iter_i = '0;
        bus.cfg_dw_i       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_enable", bus.pe_enable_o, 0);
        chk("rst_clear", bus.pe_clear_o, 0);
        chk("rst_done", bus.done_o, 0);
        chk("rst_shift", bus.pe_scale_shift_o, 0);
        chk("rst_dw", bus.pe_dw_accum_o, 0);
        @(negedge clk);
        rst = 1'b0;

        // Start and clear together: clear wins, stays idle.
        cur_qw  = 4;
        cur_kin = 2;
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        // Full tile, streams always valid.
        run_tile(8, 2, 1'b0, 0);
        chk("t1_fires", n_fire, 16);
        chk("t1_done", n_done, 1);
        chk("t1_len", steps, 2 + 16 + 1);

        // Empty tiles go straight through drain.
        run_tile(0, 5, 1'b0, 0);
        chk("qw0_fires", n_fire, 0);
        chk("qw0_len", steps, 3);
        run_tile(5, 0, 1'b1, 0);
        chk("kin0_fires", n_fire, 0);
        chk("kin0_done", n_done, 1);

        // Accumulator stalled: only MAXI beats go out.
        cur_qw  = 4;
        cur_kin = 2;
        n_fire  = 0;
        n_done  = 0;
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        repeat (10) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("stall_fires", n_fire, MAXI);
        for (int i = 0; i < 200 && m_busy; i++)
            step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("stall_total", n_fire, 8);
        chk("stall_done", n_done, 1);

        // Weight stream toggling.
        run_tile(3, 3, 1'b0, 1);
        chk("tog_fires", n_fire, 9);
        chk("tog_done", n_done, 1);

        // Abort after five beats, then a clean tile.
        cur_qw  = 8;
        cur_kin = 2;
        n_fire  = 0;
        n_done  = 0;
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 100 && n_fire < 5; i++)
            step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("abort_fires", n_fire, 5);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("abort_done", n_done, 0);
        chk("abort_idle", bus.busy_o, 0);
        run_tile(8, 2, 1'b0, 0);
        chk("after_abort_fires", n_fire, 16);
        chk("after_abort_done", n_done, 1);

        // Depthwise tile.
        run_tile(4, 3, 1'b1, 0);
        chk("dw_fires", n_fire, 12);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("dw_after", bus.pe_dw_accum_o, 0);

        // Random tiles with random handshakes.
        for (int t = 0; t < 8; t++) begin
            q = $urandom_range(0, QW_MAX);
            k = $urandom_range(0, 4);
            run_tile(q, k, 1'($urandom % 2), 2);
            chk("rnd_fires", n_fire, q * k);
            chk("rnd_done", n_done, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
